// File: rtl/clk_div_monitor_pkg.sv
// Shared definitions for the divided-clock monitor: FSM state encoding,
// default divider constants (common with the clock divider) and a helper
// for the half-period tolerance window.
package clk_div_monitor_pkg;

    // Default half-period in fast-clock cycles; also the divider's divisor basis.
    localparam int unsigned DIV_EXPECT_HALF = 32'd4;
    // Default allowed +/- deviation of a measured half-period.
    localparam int unsigned DIV_TOL         = 32'd1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_FAULT   = 2'd3
    } mon_state_e;

    // True when value lies in [expect_v - tol, expect_v + tol]; written
    // without subtraction so a small expect_v cannot underflow.
    function automatic logic in_window(input logic [31:0] value,
                                       input logic [31:0] expect_v,
                                       input logic [31:0] tol);
        return ((value + tol) >= expect_v) && (value <= (expect_v + tol));
    endfunction

endpackage

// File: rtl/clk_div_monitor_sync_edge_det.sv
// sync_edge_det: 2-flop synchronizer plus history flop for an asynchronous
// level, with registered one-cycle rise/fall strobes. edge_o is the
// unregistered edge indication so a consumer can register results that
// line up with the strobes.
module sync_edge_det (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic edge_o,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    // Synchronizer chain, history flop and registered edge strobes.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            s3_q   <= 1'b0;
            rise_o <= 1'b0;
            fall_o <= 1'b0;
        end else begin
            s1_q   <= async_i;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            rise_o <= s2_q & ~s3_q;
            fall_o <= ~s2_q & s3_q;
        end
    end

    assign edge_o = s2_q ^ s3_q;

endmodule

// File: rtl/clk_div_monitor.sv
// clk_div_monitor: fast-domain consumer of a divided clock. Produces
// rise/fall enables, measures every half-period, tracks lock against the
// expected ratio and raises a sticky fault flag when a locked clock
// misbehaves. Optional build macro CLK_DIV_MON_ERRCNT_EN adds a saturating
// count of LOCKED->FAULT transitions on err_cnt (tied to zero otherwise).
module clk_div_monitor
    import clk_div_monitor_pkg::*;
#(
    parameter int unsigned EXPECT_HALF = DIV_EXPECT_HALF,
    parameter int unsigned TOL         = DIV_TOL,
    parameter int unsigned LOCK_COUNT  = 32'd4,
    parameter int unsigned CNT_W       = 32'd8
) (
    input  logic             iCLK,
    input  logic             RST,
    input  logic             clk_in,
    input  logic             clr_err,
    output logic             rise_stb,
    output logic             fall_stb,
    output logic [CNT_W-1:0] half_period,
    output logic             period_valid,
    output logic             locked,
    output logic             err,
    output logic [7:0]       err_cnt
);

    localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 32'd1);
    localparam logic [CNT_W-1:0]  HCNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  TIMEOUT_VAL = CNT_W'(EXPECT_HALF + TOL + 32'd1);
    localparam logic [GOOD_W-1:0] GOOD_LAST   = GOOD_W'(LOCK_COUNT - 32'd1);

    logic              edge_s;
    logic [CNT_W-1:0]  hcnt_q;
    logic [CNT_W-1:0]  hcnt_d;
    logic              seen_q;
    logic              first_q;
    logic              timeout_q;
    logic              timeout_d;
    logic              meas_good_s;
    logic              meas_bad_s;
    logic              fault_s;
    mon_state_e        state_q;
    logic [GOOD_W-1:0] good_q;

    sync_edge_det u_sync (
        .clk_i   (iCLK),
        .rst_ni  (RST),
        .async_i (clk_in),
        .edge_o  (edge_s),
        .rise_o  (rise_stb),
        .fall_o  (fall_stb)
    );

    // Half-period counter next state and single-cycle timeout detection.
    always_comb begin
        hcnt_d    = hcnt_q;
        timeout_d = 1'b0;
        if (edge_s) begin
            hcnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (hcnt_q != HCNT_MAX) begin
            hcnt_d = hcnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            hcnt_d = hcnt_q;
        end
        if (seen_q && !edge_s && (hcnt_q == TIMEOUT_VAL)) begin
            timeout_d = 1'b1;
        end else begin
            timeout_d = 1'b0;
        end
    end

    // Measurement registers: counter, first-edge tracking, published period.
    always_ff @(posedge iCLK) begin
        if (!RST) begin
            hcnt_q       <= {CNT_W{1'b0}};
            seen_q       <= 1'b0;
            first_q      <= 1'b0;
            timeout_q    <= 1'b0;
            period_valid <= 1'b0;
            half_period  <= {CNT_W{1'b0}};
        end else begin
            hcnt_q       <= hcnt_d;
            seen_q       <= seen_q | edge_s;
            first_q      <= edge_s & ~seen_q;
            timeout_q    <= timeout_d;
            period_valid <= edge_s & seen_q;
            if (edge_s && seen_q) begin
                half_period <= hcnt_q;
            end
        end
    end

    // Classify the measurement published in the previous cycle.
    always_comb begin
        meas_good_s = period_valid &&
                      in_window(32'(half_period), EXPECT_HALF, TOL);
        meas_bad_s  = timeout_q ||
                      (period_valid && !in_window(32'(half_period), EXPECT_HALF, TOL));
        fault_s     = (state_q == ST_LOCKED) && meas_bad_s;
    end

    // Lock FSM with registered locked flag and sticky err (fault beats clear).
    always_ff @(posedge iCLK) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            good_q  <= {GOOD_W{1'b0}};
            locked  <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (first_q) begin
                        state_q <= ST_MEASURE;
                        good_q  <= {GOOD_W{1'b0}};
                    end
                    locked <= 1'b0;
                end
                ST_MEASURE: begin
                    if (meas_good_s) begin
                        if (good_q == GOOD_LAST) begin
                            state_q <= ST_LOCKED;
                            locked  <= 1'b1;
                        end else begin
                            good_q <= good_q + {{(GOOD_W-1){1'b0}}, 1'b1};
                        end
                    end else if (meas_bad_s) begin
                        good_q <= {GOOD_W{1'b0}};
                    end
                end
                ST_LOCKED: begin
                    if (meas_bad_s) begin
                        state_q <= ST_FAULT;
                        locked  <= 1'b0;
                    end
                end
                ST_FAULT: begin
                    if (meas_good_s) begin
                        state_q <= ST_MEASURE;
                        good_q  <= {{(GOOD_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    good_q  <= {GOOD_W{1'b0}};
                    locked  <= 1'b0;
                end
            endcase
            if (fault_s) begin
                err <= 1'b1;
            end else if (clr_err) begin
                err <= 1'b0;
            end
        end
    end

`ifdef CLK_DIV_MON_ERRCNT_EN
    // Saturating LOCKED->FAULT counter; only reset clears it.
    always_ff @(posedge iCLK) begin
        if (!RST) begin
            err_cnt <= 8'd0;
        end else if (fault_s && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`else
    assign err_cnt = 8'd0;
`endif

endmodule
